// File: rtl/lz_pkg.sv
// Shared definitions for the leading-zero count / de-normalize datapath.
// Holds the de-normalizer state encoding, the default data width, the
// count-width derivation and the saturated-count constant.
package lz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lz_state_t;

  localparam int LZ_WIDTH = 32;

  // A count must encode 0..WIDTH inclusive, hence one bit more than log2.
  function automatic int lz_cw(input int width);
    return $clog2(width) + 1;
  endfunction

  // Count value meaning "every bit was zero" for the default width.
  localparam int LZ_SAT_CNT = LZ_WIDTH;

endpackage

// File: rtl/lz_shift_stage.sv
// One binary stage of the iterative right shifter.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: data in, enable (count bit for this stage), stage index k,
//        result = enable ? data >> 2^k : data (logical, zero fill).
module lz_shift_stage #(
  parameter int WIDTH = 32,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic [KW-1:0]    stage,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (enable) begin
      result = data >> (1 << stage);
    end
  end

endmodule

// File: rtl/lz_denormalizer.sv
// Restores a word from its normalized form plus leading-zero count by an
// iterative right shift, one binary stage per cycle.
// Latency: accept at edge T, out_valid from edge T+STAGES+1; no overlap.
// Backpressure: Dout/out_valid held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst (async, active high); in_valid/in_ready with Din, Cnt;
//        out_valid/out_ready with Dout; norm_err (normalization flag).
// Optional: define LZ_DENORM_NORM_CHECK_EN to flag inputs whose MSB is clear
//           while Cnt < WIDTH; otherwise norm_err is tied low.
module lz_denormalizer
  import lz_pkg::*;
#(
  parameter int WIDTH  = LZ_WIDTH,
  parameter int CW     = lz_cw(WIDTH),
  parameter int STAGES = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Din,
  input  logic [CW-1:0]    Cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Dout,
  output logic             norm_err
);

  localparam int            KW      = $clog2(STAGES);
  localparam logic [CW-1:0] SAT_CNT = CW'(WIDTH);
  localparam logic [KW-1:0] LAST_K  = KW'(STAGES - 1);

  lz_state_t        state, state_n;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_q;
  logic [KW-1:0]    k_q;
  logic             out_valid_q;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign Dout      = data_q;

  // A single stage instance; the stage index selects the shift distance.
  lz_shift_stage #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_stage (
    .data   (data_q),
    .enable (cnt_q[k_q]),
    .stage  (k_q),
    .result (shifted)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (k_q == LAST_K) state_n = DONE;
      DONE:    if (out_valid_q && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept) begin
            // Any count at or above WIDTH means the original word was zero;
            // loading zero avoids relying on the high count bits to clear it.
            data_q <= (Cnt >= SAT_CNT) ? '0 : Din;
            cnt_q  <= Cnt;
            k_q    <= '0;
          end
        end
        SHIFT: begin
          data_q <= shifted;
          k_q    <= k_q + KW'(1);
        end
        DONE: begin
          // out_valid is a registered flag raised on the first DONE cycle,
          // giving a clean registered Dout/out_valid pair to the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LZ_DENORM_NORM_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= !Din[WIDTH-1] && (Cnt < SAT_CNT);
    end
  end

  assign norm_err = out_valid_q && err_q;
`else
  assign norm_err = 1'b0;
`endif

endmodule

// File: tb/tb_lz_denormalizer.sv
module tb_lz_denormalizer;
  import lz_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Din;
  logic [5:0]  Cnt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Dout;
  logic        norm_err;

  int tests = 0;
  int fails = 0;

  lz_denormalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Din       (Din),
    .Cnt       (Cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Dout      (Dout),
    .norm_err  (norm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: the original word is the normalized word moved right by the
  // count; a count of WIDTH or more stands for an all-zero word.
  function automatic logic [31:0] model(input logic [31:0] din, input logic [5:0] cnt);
    if (int'(cnt) >= LZ_SAT_CNT) return 32'h0;
    return din >> cnt;
  endfunction

  function automatic logic model_err(input logic [31:0] din, input logic [5:0] cnt);
`ifdef LZ_DENORM_NORM_CHECK_EN
    return (din[31] == 1'b0) && (int'(cnt) < LZ_SAT_CNT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lzc(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) return 31 - i;
    end
    return 32;
  endfunction

  // Presents one input and leaves the bench at the negedge after acceptance.
  task automatic start(input logic [31:0] din, input logic [5:0] cnt, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    Din      = din;
    Cnt      = cnt;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    Din      = $urandom;
    Cnt      = 6'($urandom);
  endtask

  // Counts rising edges until out_valid, bounded so a dead DUT cannot hang.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic xact(input logic [31:0] din, input logic [5:0] cnt,
                      input logic [31:0] exp, input string tag);
    int e;
    start(din, cnt, tag);
    wait_valid(e);
    check({tag, "_latency"}, 32'(e), 32'd6);
    check({tag, "_dout"}, Dout, exp);
    check({tag, "_norm_err"}, 32'(norm_err), 32'(model_err(din, cnt)));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          e;
    logic [31:0] held;
    logic [31:0] x;
    logic [31:0] n;
    int          c;
    bit          ghost;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Din       = '0;
    Cnt       = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", Dout, 32'd0);
    check("rst_norm_err", 32'(norm_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed boundaries
    xact(32'h80000000, 6'd0,  32'h80000000, "cnt0");
    xact(32'hC0000000, 6'd4,  model(32'hC0000000, 6'd4), "cnt4");
    check("cnt4_const", model(32'hC0000000, 6'd4), 32'h0C000000);
    xact(32'h80000000, 6'd31, 32'h00000001, "cnt31");
    xact(32'hFFFFFFFF, 6'd32, 32'h00000000, "cnt32");
    xact(32'hFFFFFFFF, 6'd63, 32'h00000000, "cnt63");
    xact(32'hFFFFFFFF, 6'd40, 32'h00000000, "cnt40");
    xact(32'h40000000, 6'd3,  32'h08000000, "unnorm");

    // Backpressure: result held, new inputs ignored while in DONE
    out_ready = 1'b0;
    start(32'hA5000000, 6'd8, "bp");
    wait_valid(e);
    check("bp_latency", 32'(e), 32'd6);
    check("bp_dout", Dout, 32'h00A50000);
    held = Dout;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      Din      = 32'h80000000 | $urandom;
      Cnt      = 6'($urandom_range(0, 31));
      @(posedge clk);
      @(negedge clk);
      check("bp_dout_stable", Dout, held);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    ghost = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    check("bp_no_ghost", 32'(ghost), 32'd0);

    // Reset in the middle of shifting aborts the transaction
    start(32'hF0000000, 6'd7, "rst_mid");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_dout", Dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ghost = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    check("rst_mid_no_output", 32'(ghost), 32'd0);
    xact(32'hB0000000, 6'd5, 32'h05800000, "after_rst");

    // Round trip: normalize a random word, feed it back, expect the original
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: x = 32'h0;
        1: x = 32'h1;
        2: x = 32'hFFFFFFFF;
        default: x = $urandom >> $urandom_range(0, 31);
      endcase
      c = lzc(x);
      n = (c >= 32) ? 32'h0 : (x << c);
      xact(n, 6'(c), x, "round_trip");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
